// File: rtl/io_bridge_pkg.sv
// Shared definitions for the IO-port to simple-bus bridge: FSM encoding and
// the default error word returned on timeout.
package io_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] DEFAULT_ERR_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/io_bridge_timer.sv
// Saturating 16-bit cycle counter; expired once the count reaches limit-1.
module io_bridge_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        enable,
    input  logic [15:0] limit,
    output logic        expired
);

    logic [15:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != 16'hFFFF) begin
            count <= count + 16'd1;
        end
    end

    // A limit of zero means the timeout is disabled.
    assign expired = (limit != 16'd0) && (count >= limit - 16'd1);

endmodule

// File: rtl/io_to_axi.sv
// Bridges single-cycle processor IO strobes onto a valid/ready request bus
// with a pulsed response, returning ERR_DATA if the response never arrives.
module io_to_axi
    import io_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = DEFAULT_ERR_DATA
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        io_addr_strobe,
    input  logic        io_read_strobe,
    input  logic        io_write_strobe,
    input  logic [31:0] io_addr,
    input  logic [3:0]  io_byte_enable,
    input  logic [31:0] io_write_data,
    output logic [31:0] io_read_data,
    output logic        io_ready,
    output logic        avalid,
    input  logic        aready,
    output logic        awe,
    output logic [31:2] aaddr,
    output logic [31:0] adata,
    output logic [3:0]  astrb,
    input  logic        bvalid,
    input  logic [31:0] bdata,
    output logic        busy,
    output logic        timeout
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES);

    state_t state;
    logic   start;
    logic   done;
    logic   expired;
    logic   unused_addr_lsb;

    assign unused_addr_lsb = &{1'b0, io_addr[1:0]};

    assign start = (state == IDLE) && io_addr_strobe && (io_read_strobe || io_write_strobe);
    assign done  = (state == REQ  && aready && bvalid) ||
                   (state == RESP && bvalid);

    io_bridge_timer u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (start),
        .enable  (state != IDLE),
        .limit   (LIMIT),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            avalid       <= 1'b0;
            awe          <= 1'b0;
            aaddr        <= '0;
            adata        <= '0;
            astrb        <= '0;
            io_ready     <= 1'b0;
            io_read_data <= '0;
            busy         <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            io_ready     <= 1'b0;
            io_read_data <= '0;
            timeout      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= REQ;
                        avalid <= 1'b1;
                        busy   <= 1'b1;
                        awe    <= io_write_strobe;
                        aaddr  <= io_addr[31:2];
                        adata  <= io_write_data;
                        astrb  <= io_byte_enable;
                    end
                end
                REQ, RESP: begin
                    // A response in the expiry cycle wins over the timeout.
                    if (done || expired) begin
                        state        <= IDLE;
                        avalid       <= 1'b0;
                        busy         <= 1'b0;
                        io_ready     <= 1'b1;
                        io_read_data <= done ? bdata : ERR_DATA;
                        timeout      <= !done;
                    end else if (state == REQ && aready) begin
                        state  <= RESP;
                        avalid <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    avalid <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/io_to_axi.md
IO_TO_AXI -- requirements
Module: io_to_axi

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, meaning cycles allowed from avalid rise to bvalid; 0 disables timeout.
REQ-002 Parameter ERR_DATA, default 32'hFFFFFFFF, meaning io_read_data value returned on timeout.
REQ-003 rst_n  input  1  async active-low reset.
REQ-004 clk  input  1  sole clock, all logic on rising edge.
REQ-005 io_addr_strobe  input  1  single-cycle transaction start from processor IO port.
REQ-006 io_read_strobe / io_write_strobe  input  1 each  qualify direction; valid only with io_addr_strobe.
REQ-007 io_addr  input  32  byte address; bits [1:0] ignored.
REQ-008 io_byte_enable  input  4  write byte lanes.
REQ-009 io_write_data  input  32  write data.
REQ-010 io_read_data  output  32  read data, valid while io_ready=1.
REQ-011 io_ready  output  1  single-cycle completion pulse.
REQ-012 avalid  output  1  request valid on simple bus.
REQ-013 aready  input  1  request accept; transfer when avalid && aready.
REQ-014 awe  output  1  1 = write.
REQ-015 aaddr  output  [31:2]  word address.
REQ-016 adata  output  32  write data.
REQ-017 astrb  output  4  byte strobes.
REQ-018 bvalid  input  1  single-cycle response pulse.
REQ-019 bdata  input  32  response data, valid with bvalid.
REQ-020 busy  output  1  transaction outstanding.
REQ-021 timeout  output  1  single-cycle pulse coinciding with io_ready of a timed-out transaction.

Function
REQ-022 The FSM SHALL have states IDLE, REQ, RESP.
REQ-023 IDLE: io_addr_strobe && (read||write strobe) SHALL capture addr[31:2], write flag, byte_enable, write_data and go to REQ next cycle; strobe without direction SHALL be ignored.
REQ-024 REQ: avalid=1, awe/aaddr/adata/astrb SHALL hold captured values, stable until aready sampled high.
REQ-025 REQ with aready=1 and bvalid=0 SHALL go to RESP; avalid SHALL drop the next cycle.
REQ-026 REQ with aready=1 and bvalid=1 in the same cycle SHALL complete as in REQ-027.
REQ-027 RESP with bvalid=1 SHALL latch bdata and, next cycle, pulse io_ready for exactly one cycle with io_read_data=latched bdata, returning to IDLE.
REQ-028 Latency: strobe cycle N -> avalid high from N+1; bvalid cycle M -> io_ready at M+1.
REQ-029 Writes SHALL also return io_ready; io_read_data SHALL equal bdata for writes (don't-care to processor).
REQ-030 io_read_data SHALL be 0 whenever io_ready=0.
REQ-031 A 16-bit counter SHALL clear on entering REQ and increment each cycle in REQ/RESP, saturating at 65535.
REQ-032 When TIMEOUT_CYCLES>0 and counter reaches TIMEOUT_CYCLES-1 without completion, next cycle SHALL pulse io_ready and timeout with io_read_data=ERR_DATA, drop avalid, enter IDLE.
REQ-033 Completion and timeout in the same cycle SHALL resolve as completion (timeout=0).
REQ-034 bvalid while IDLE (late response after timeout) SHALL be ignored.
REQ-035 io_addr_strobe while busy=1 SHALL be ignored; io_ready SHALL NOT be generated for it.
REQ-036 busy SHALL be 1 in REQ and RESP, 0 in IDLE.
REQ-037 io_addr_strobe in the io_ready cycle SHALL be accepted (FSM already IDLE).

Reset
REQ-038 rst_n low SHALL asynchronously force IDLE, avalid=0, awe=0, aaddr=0, adata=0, astrb=0, io_ready=0, io_read_data=0, busy=0, timeout=0, counter=0.
REQ-039 Reset mid-transaction SHALL abandon it with no io_ready; post-reset bvalid SHALL be ignored.

Structure
REQ-040 FSM state encoding and default ERR_DATA SHALL live in shared package io_bridge_pkg.
REQ-041 Timeout counter SHALL be sub-module io_bridge_timer (clear, enable, limit, expired).

Verification
REQ-042 Read: strobe addr 32'hC0000010, aready=1, bvalid 3 cycles later with 32'h12345678 -> aaddr=30'h30000004, awe=0, io_ready once with 32'h12345678.
REQ-043 Write: strobe addr 32'h00000104, data 32'hA5A5A5A5, be 4'b0011, aready low 4 cycles -> avalid held 5 cycles with stable fields, awe=1, astrb=4'b0011, one io_ready.
REQ-044 aready and bvalid in same cycle, bdata 32'h0000BEEF -> io_ready next cycle with 32'h0000BEEF, no RESP dwell.
REQ-045 TIMEOUT_CYCLES=8, no bvalid -> io_ready+timeout at cycle 9 after avalid rise, data 32'hFFFFFFFF; late bvalid ignored.
REQ-046 Second strobe during RESP -> ignored, exactly one io_ready.
REQ-047 rst_n low during REQ -> avalid=0 immediately, no io_ready, new transaction completes normally after release.
